// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Op codes, one-hot FSM states and the default data width.
package md_pkg;

  localparam int MD_DATA_W = 32;

  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_MULU = 3'b001;
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_DIVU = 3'b011;
  localparam logic [2:0] MD_MTHI = 3'b100;
  localparam logic [2:0] MD_MTLO = 3'b101;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_START = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } md_state_e;

endpackage

// File: rtl/md_hilo_regs.sv
// Architectural HI/LO register pair.
// Independent write enables, synchronous reset to zero.
module md_hilo_regs
  import md_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hi_we,
  input  logic [DATA_W-1:0] i_hi_d,
  input  logic              i_lo_we,
  input  logic [DATA_W-1:0] i_lo_d,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: one request at a time, owns HI/LO.
// Optional WAIT timeout abort is enabled by defining MD_TIMEOUT_EN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int DATA_W  = MD_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              unit_busy,
  input  logic [DATA_W-1:0] unit_hi,
  input  logic [DATA_W-1:0] unit_lo,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              mul_start,
  output logic              mulu_start,
  output logic              div_start,
  output logic              divu_start,
  output logic              stall,
  output logic              ack,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div0,
  output logic              err
);

  md_state_e         r_state;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_ack;
  logic              r_div0;

  logic              w_is_div;
  logic              w_div_zero;
  logic              w_accept;
  logic              w_idle_req;
  logic              w_cap;
  logic              w_hi_we;
  logic              w_lo_we;
  logic [DATA_W-1:0] w_hi_d;
  logic [DATA_W-1:0] w_lo_d;

  assign w_is_div   = (op == MD_DIV) || (op == MD_DIVU);
  assign w_div_zero = w_is_div && (rt_val == '0);
  assign w_accept   = !op[2] && !w_div_zero;
  assign w_idle_req = (r_state == S_IDLE) && req;
  assign w_cap      = (r_state == S_WAIT) && !unit_busy;

  // HI/LO are written either by MTHI/MTLO in IDLE or by result capture.
  assign w_hi_we = w_cap || (w_idle_req && (op == MD_MTHI));
  assign w_lo_we = w_cap || (w_idle_req && (op == MD_MTLO));
  assign w_hi_d  = w_cap ? unit_hi : rs_val;
  assign w_lo_d  = w_cap ? unit_lo : rs_val;

`ifdef MD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= MD_MUL;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_ack   <= 1'b0;
      r_div0  <= 1'b0;
`ifdef MD_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack  <= 1'b0;
      r_div0 <= 1'b0;
`ifdef MD_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (req) begin
            if (w_accept) begin
              r_op    <= op;
              r_op_a  <= rs_val;
              r_op_b  <= rt_val;
              r_state <= S_START;
            end else begin
              r_ack   <= 1'b1;
              r_div0  <= w_div_zero;
              r_state <= S_DONE;
            end
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef MD_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (!unit_busy) begin
            r_ack   <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef MD_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  md_hilo_regs #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk     (clk),
    .rst     (rst),
    .i_hi_we (w_hi_we),
    .i_hi_d  (w_hi_d),
    .i_lo_we (w_lo_we),
    .i_lo_d  (w_lo_d),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  assign mul_start  = (r_state == S_START) && (r_op == MD_MUL);
  assign mulu_start = (r_state == S_START) && (r_op == MD_MULU);
  assign div_start  = (r_state == S_START) && (r_op == MD_DIV);
  assign divu_start = (r_state == S_START) && (r_op == MD_DIVU);

  assign stall = (r_state == S_START) || (r_state == S_WAIT) || w_idle_req;
  assign ack   = r_ack;
  assign div0  = r_div0;
  assign op_a  = r_op_a;
  assign op_b  = r_op_b;
`ifdef MD_TIMEOUT_EN
  assign err   = r_err;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: vector table, hand sequences, random ops
// against a transaction-level HI/LO model and a modelled busy unit.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        unit_busy;
  logic [31:0] unit_hi, unit_lo;
  logic [31:0] op_a, op_b;
  logic        mul_start, mulu_start, div_start, divu_start;
  logic        stall, ack, div0, err;
  logic [31:0] hi, lo;

  md_sequencer #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .unit_busy(unit_busy), .unit_hi(unit_hi), .unit_lo(unit_lo),
    .op_a(op_a), .op_b(op_b),
    .mul_start(mul_start), .mulu_start(mulu_start),
    .div_start(div_start), .divu_start(divu_start),
    .stall(stall), .ack(ack), .hi(hi), .lo(lo),
    .div0(div0), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          n;
    logic [31:0] rh, rl;
    int          lat;
    logic        div0;
    logic [31:0] ehi, elo;
  } vec_t;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] m_hi, m_lo, m_opa, m_opb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] starts();
    return {divu_start, div_start, mulu_start, mul_start};
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t r;
    bit is_div, short_op;
    r = v;
    is_div   = (v.op == 3'd2) || (v.op == 3'd3);
    short_op = v.op[2] || (is_div && v.rt == 0);
    r.div0 = is_div && (v.rt == 0);
    r.lat  = short_op ? 1 : 3 + v.n;
    r.ehi  = m_hi;
    r.elo  = m_lo;
    if (v.op == 3'd4) r.ehi = v.rs;
    if (v.op == 3'd5) r.elo = v.rs;
    if (!short_op) begin
      r.ehi = v.rh;
      r.elo = v.rl;
    end
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    int busy_left, nstart, first_start, ack_cyc;
    logic [3:0] which, st, exp_which;
    bit stall_ok;
    busy_left = 0; nstart = 0; first_start = -1; ack_cyc = -1;
    which = 0; stall_ok = 1;
    if (v.lat != 1) begin
      m_opa = v.rs;
      m_opb = v.rt;
    end
    for (int cyc = 0; cyc < 200 && ack_cyc < 0; cyc++) begin
      req = 1'b1; op = v.op; rs_val = v.rs; rt_val = v.rt;
      unit_busy = (busy_left > 0);
      unit_hi = unit_busy ? $urandom : v.rh;
      unit_lo = unit_busy ? $urandom : v.rl;
      #2;
      st = starts();
      if (st != 0) begin
        nstart += $countones(st);
        which |= st;
        if (first_start < 0) first_start = cyc;
      end
      if (stall !== !ack) stall_ok = 0;
      if (ack) begin
        ack_cyc = cyc;
        chk("hi", 64'(hi), 64'(v.ehi));
        chk("lo", 64'(lo), 64'(v.elo));
        chk("div0", 64'(div0), 64'(v.div0));
        chk("err", 64'(err), 64'd0);
        chk("op_ab", {op_a, op_b}, {m_opa, m_opb});
      end
      if (st != 0) busy_left = v.n;
      else if (busy_left > 0) busy_left--;
      step();
    end
    req = 1'b0;
    exp_which = (v.lat == 1) ? 4'd0 : 4'(1 << v.op[1:0]);
    chk("latency", 64'(ack_cyc), 64'(v.lat));
    chk("nstart", 64'(nstart), (v.lat == 1) ? 64'd0 : 64'd1);
    chk("which_start", 64'(which), 64'(exp_which));
    if (v.lat != 1) chk("start_cycle", 64'(first_start), 64'd1);
    chk("stall", 64'(stall_ok), 64'd1);
    m_hi = v.ehi;
    m_lo = v.elo;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    int ack_cyc, nst;
    bit stall_ok, bad;
    tbl[0] = '{3'd4, 32'h12345678, 32'h0, 0, 32'h0, 32'h0, 1, 1'b0, 32'h12345678, 32'h0};
    tbl[1] = '{3'd1, 32'hFFFFFFFF, 32'h2, 3, 32'h1, 32'hFFFFFFFE, 6, 1'b0, 32'h1, 32'hFFFFFFFE};
    tbl[2] = '{3'd4, 32'hA5A5A5A5, 32'h0, 0, 32'h0, 32'h0, 1, 1'b0, 32'hA5A5A5A5, 32'hFFFFFFFE};
    tbl[3] = '{3'd5, 32'hA5A5A5A5, 32'h0, 0, 32'h0, 32'h0, 1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[4] = '{3'd2, 32'h7, 32'h0, 2, 32'h11, 32'h22, 1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[5] = '{3'd3, 32'h9, 32'h0, 2, 32'h33, 32'h44, 1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[6] = '{3'd6, 32'h1, 32'h1, 0, 32'h0, 32'h0, 1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[7] = '{3'd7, 32'h1, 32'h0, 0, 32'h0, 32'h0, 1, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[8] = '{3'd0, 32'h3, 32'h5, 0, 32'h0, 32'hF, 3, 1'b0, 32'h0, 32'hF};
    tbl[9] = '{3'd2, 32'd100, 32'd7, 5, 32'd2, 32'd14, 8, 1'b0, 32'd2, 32'd14};

    rst = 1'b1; req = 1'b0; op = 0; rs_val = 0; rt_val = 0;
    unit_busy = 1'b0; unit_hi = 0; unit_lo = 0;
    m_hi = 0; m_lo = 0; m_opa = 0; m_opb = 0;
    step(); step();
    #1;
    chk("reset_state",
        {hi, lo, op_a, op_b, 28'd0, starts(), stall, ack, div0, err},
        {128'd0, 32'd0, 4'd0});
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // back-to-back: req stays high through DONE into the next op
    rv = '{3'd1, 32'h10, 32'h20, 1, 32'hAB, 32'hCD, 0, 1'b0, 0, 0};
    rv = predict(rv); run_op(rv);
    rv = '{3'd3, 32'h40, 32'h6, 2, 32'h4, 32'hA, 0, 1'b0, 0, 0};
    rv = predict(rv); run_op(rv);
    rv = '{3'd5, 32'h77, 32'h0, 0, 32'h0, 32'h0, 0, 1'b0, 0, 0};
    rv = predict(rv); run_op(rv);

    // reset during WAIT of a DIVU
    for (int cyc = 0; cyc < 4; cyc++) begin
      req = 1'b1; op = 3'd3; rs_val = 32'd50; rt_val = 32'd3;
      unit_busy = (cyc >= 2); unit_hi = $urandom; unit_lo = $urandom;
      if (cyc == 3) rst = 1'b1;
      #2;
      step();
    end
    rst = 1'b0; req = 1'b0;
    #2;
    chk("rst_wait_hilo", {hi, lo, op_a, op_b}, 128'd0);
    chk("rst_wait_idle", {28'd0, starts(), stall, ack, div0, err}, 36'd0);
    bad = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      unit_busy = (cyc < 8);
      unit_hi = $urandom; unit_lo = $urandom;
      #1;
      if (ack || stall || starts() != 0) bad = 1;
      step();
    end
    chk("rst_no_ack", 64'(bad), 64'd0);
    m_hi = 0; m_lo = 0; m_opa = 0; m_opb = 0;
    rv = '{3'd5, 32'h5, 32'h0, 0, 32'h0, 32'h0, 0, 1'b0, 0, 0};
    rv = predict(rv); run_op(rv);

    for (int k = 0; k < 40; k++) begin
      rv.op = 3'($urandom_range(0, 7));
      rv.rs = $urandom;
      rv.rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rv.n  = $urandom_range(0, 6);
      rv.rh = $urandom;
      rv.rl = $urandom;
      rv = predict(rv);
      run_op(rv);
    end

    // unit busy stuck high
    ack_cyc = -1; stall_ok = 1; nst = 0;
    for (int cyc = 0; cyc < 40 && ack_cyc < 0; cyc++) begin
      req = 1'b1; op = 3'd0; rs_val = 32'h1; rt_val = 32'h1;
      unit_busy = 1'b1; unit_hi = $urandom; unit_lo = $urandom;
      #2;
      nst += $countones(starts());
      if (ack) begin
        ack_cyc = cyc;
        chk("to_err", 64'(err), 64'd1);
        chk("to_hilo", {hi, lo}, {m_hi, m_lo});
      end else if (stall !== 1'b1) stall_ok = 0;
      step();
    end
    req = 1'b0;
    chk("to_nstart", 64'(nst), 64'd1);
    chk("to_stall", 64'(stall_ok), 64'd1);
`ifdef MD_TIMEOUT_EN
    chk("to_latency", 64'(ack_cyc), 64'd6);
`else
    chk("to_no_ack", 64'(ack_cyc), -64'sd1);
`endif
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    chk("final_reset", {hi, lo, 3'd0, stall}, 68'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Sequences the iterative multiply/divide units (mul, mulu, div, divu) for the multicycle CPU and owns the HI/LO register pair.
- Accepts one request at a time from the main controller.
- Issues exactly one start pulse to the selected unit and waits for the unit's busy to clear.
- Captures the 64-bit result into HI/LO.
- Holds the main controller stalled until a one-cycle ack.
- Also services MTHI/MTLO writes.

Parameters:
- DATA_W, 32, width of operands, HI and LO.
- TIMEOUT, 64, maximum WAIT cycles before abort; used only with MD_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request; held high by the controller until ack.
- op  in  3  000 MUL, 001 MULU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- rs_val  in  DATA_W  operand A; also the MTHI/MTLO data.
- rt_val  in  DATA_W  operand B (divisor for DIV/DIVU).
- unit_busy  in  1  OR of the four units' busy flags.
- unit_hi  in  DATA_W  selected unit's high result (product high / remainder).
- unit_lo  in  DATA_W  selected unit's low result (product low / quotient).
- op_a, op_b  out  DATA_W  operands latched at accept; stable until the next accept.
- mul_start, mulu_start, div_start, divu_start  out  1  one-cycle start pulses.
- stall  out  1  freeze the main controller.
- ack  out  1  one-cycle completion pulse.
- hi, lo  out  DATA_W  architectural HI/LO.
- div0  out  1  asserted with ack when a DIV/DIVU divisor was 0.
- err  out  1  timeout abort flag, asserted with ack.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; hi=lo=op_a=op_b=0; all start pulses, ack, div0, err = 0. A reset mid-operation abandons the operation with no HI/LO update; unit_busy is ignored until the next accept.
- States, one-hot: IDLE, START, WAIT, DONE.
- IDLE:
  - no req: stay in IDLE.
  - req with MTHI: hi<=rs_val; go to DONE.
  - req with MTLO: lo<=rs_val; go to DONE.
  - req with reserved op: no change; go to DONE.
  - req with DIV/DIVU and rt_val==0: no start pulse, HI/LO unchanged, div0 set for DONE; go to DONE.
  - req with any other arithmetic op: latch op, op_a<=rs_val, op_b<=rt_val; go to START.
- START: exactly one of the four start pulses is high for this single cycle, selected by the latched op; go to WAIT.
- WAIT:
  - unit_busy==0: hi<=unit_hi, lo<=unit_lo on this edge; go to DONE. A zero-latency unit therefore costs exactly one WAIT cycle.
  - otherwise: stay in WAIT.
- DONE: ack=1 for one cycle; go to IDLE. req seen in DONE is not accepted.
- stall = (state==START or WAIT) or (state==IDLE and req). Combinational; low in DONE.
- Latency from the req cycle (cycle 0) to ack:
  - MTHI/MTLO/reserved/div-by-zero: ack in cycle 1.
  - Arithmetic with a unit busy for N cycles after the start edge: ack in cycle 3+N.
- HI/LO change only on the edges above; they are never partially written.
- hi/lo are registered outputs; the new value is visible in the ack cycle.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entering WAIT.
  - If the counter reaches TIMEOUT with unit_busy still 1, go to DONE with HI/LO unchanged and err=1 in the ack cycle.
- Undefined: no counter; WAIT persists indefinitely; err tied to 0.

Decomposition:
- Shared package md_pkg holds:
  - op encodings: MD_MUL, MD_MULU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - one-hot state localparams.
  - the DATA_W default.
- One natural sub-module: md_hilo_regs, the HI/LO pair with independent write enables and a reset to 0. Everything else stays flat.

Test Plan:
- Reset, then MTHI rs=0x12345678 → ack in cycle 1, hi=0x12345678, lo=0, stall high in cycle 0 only.
- MULU rs=0xFFFFFFFF rt=2, unit busy 3 cycles returning 0x00000001/0xFFFFFFFE → mulu_start pulses once in cycle 1, ack in cycle 6, hi=1, lo=0xFFFFFFFE.
- DIV rt=0 with hi=lo=0xA5A5A5A5 preloaded → no start pulse, ack+div0 in cycle 1, HI/LO unchanged.
- rst asserted during WAIT of DIVU → next cycle state IDLE, hi=lo=0, ack never asserted, a fresh MTLO 0x5 then completes normally.
- Back-to-back: req held through DONE → no second accept in the ack cycle; the second operation starts only when req is sampled in IDLE, and only one start pulse is issued per accepted request.
- MD_TIMEOUT_EN, TIMEOUT=4, busy stuck high → ack+err after 4 WAIT cycles, HI/LO unchanged; without the macro, stall stays high.
